pipe_stage_chain: RTL and testbench
===================================

Name: pipe_stage_chain

Overview:
- Parametrised, multi-stage pipeline register carrying one control bundle and one data bundle per entry, with a valid bit per stage.
- Replaces fixed per-boundary registers (IF/ID ... MEM/WB) with one generic block.
- Adds per-stage valid tracking, flush, bubble collapsing under a downstream stall, upstream backpressure and bubble-gated control outputs.

Parameters:
- CTRL_W, 2, width of control bundle (e.g. RegWrite, MemtoReg); forced to 0 on bubbles.
- DATA_W, 69, width of data bundle (e.g. rd + two 32-bit values); not gated.
- DEPTH, 1, number of register stages (>=1); stage 0 is input side, stage DEPTH-1 drives outputs.

Ports:
- clk_i  input  1  clock, rising edge
- rst_i  input  1  reset, synchronous, active-low
- valid_i  input  1  upstream entry present
- ctrl_i  input  CTRL_W  upstream control bundle
- data_i  input  DATA_W  upstream data bundle
- stall_i  input  1  downstream cannot accept output entry this cycle
- flush_i  input  1  discard all entries
- valid_o  output  1  output stage holds a valid entry
- ctrl_o  output  CTRL_W  output control; 0 when valid_o=0
- data_o  output  DATA_W  output data; raw stage contents
- busy_o  output  1  upstream must hold; valid_i ignored this cycle
- occ_o  output  $clog2(DEPTH+1)  count of valid stages

Behaviour:
- Reset (rst_i=0 at a rising edge):
  - All valid bits, control registers and data registers cleared.
  - Afterwards valid_o=0, ctrl_o=0, data_o=0, occ_o=0, busy_o=0.
  - Reset overrides flush, stall and input.
- Stage advance, evaluated from output to input each cycle:
  - Output stage DEPTH-1 "moves" when !stall_i or it is empty.
  - Stage i<DEPTH-1 moves when it is empty or stage i+1 moves.
  - A moving stage i loads stage i-1 (stage 0 loads the input) together with that stage's valid bit.
  - A non-moving stage holds all bits.
  - An empty stage always moves, so bubbles collapse while stall_i=1.
- Input acceptance:
  - busy_o = (stage 0 cannot move) = all DEPTH stages valid && stall_i (combinational).
  - Entry accepted when valid_i && !busy_o.
  - If stage 0 moves with valid_i=0, stage 0 takes a bubble; its data contents are don't-care but are loaded from data_i.
- Output drain: when stall_i=0 and valid_o=1, the entry is consumed at that edge.
- Latency:
  - With no stall and no flush, an entry accepted at edge N appears on the outputs after edge N+DEPTH-1, i.e. DEPTH cycles after presentation.
  - Throughput is 1 entry/cycle.
- Flush:
  - flush_i=1 at an edge clears every valid bit and drops the current input, including an input accepted the same cycle.
  - Data registers are not cleared.
  - Flush has priority over stall; busy_o is still computed normally in the flush cycle.
- Output gating: ctrl_o = valid_o ? ctrl of stage DEPTH-1 : 0, so a bubble never asserts RegWrite.
- occ_o:
  - Popcount of the valid bits; registered-state based, with no combinational path from the inputs.
  - Range is 0..DEPTH.
- DEPTH=1: the block degenerates to a single register with hold when stall_i && valid, and loads when empty even while stall_i=1.
- Combinational paths: stall_i -> busy_o only. No path from valid_i, ctrl_i or data_i to any output.

Optional Feature:
- Macro PIPE_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt_o [15:0], a saturating count of cycles with stall_i && valid_o at a rising edge.
  - Cleared only by reset; flush does not clear it; holds at 16'hFFFF.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset: DEPTH=3, drive rst_i=0 for 2 cycles with valid_i=1, data_i=69'h1 -> valid_o=0, ctrl_o=0, data_o=0, occ_o=0, busy_o=0 after the reset edge.
- Latency/throughput: DEPTH=3, stream data 1,2,3,4 with ctrl 2'b11 on consecutive cycles, no stall -> data_o=1 after the 3rd edge, then 2,3,4 on following cycles, with valid_o=1 and ctrl_o=2'b11 throughout.
- Bubble collapse: DEPTH=3, send A, idle, B, then hold stall_i=1 -> A holds at output, B advances into stage 1 behind A, occ_o=2, busy_o=0.
  - A further entry C fills stage 0 -> occ_o=3 and busy_o=1.
  - With busy_o=1, valid_i=1 D is ignored.
- Stall release: from the full state above, drop stall_i -> A, B, C emerge on 3 consecutive cycles; D is accepted the cycle busy_o falls.
- Flush: DEPTH=2, full with stall_i=1, assert flush_i together with valid_i=1 E -> next cycle valid_o=0, ctrl_o=0, occ_o=0, and E never appears.
- Stall counter (with PIPE_STALL_CNT_EN): hold stall_i=1 with valid_o=1 for 5 cycles, then 3 cycles with valid_o=0 -> stall_cnt_o=5; a flush leaves it at 5.

Source files
------------

// File: rtl/pipe_stage_chain_if.sv
// pipe_stage_chain_if: bundle of the pipeline chain's handshake and data signals.
// Macro PIPE_STALL_CNT_EN adds stall_cnt_o to the bundle.
//
// Signals:
//   valid_i, ctrl_i, data_i : upstream entry (master drives)
//   stall_i, flush_i        : downstream/global control (master drives)
//   valid_o, ctrl_o, data_o : output stage contents (slave drives)
//   busy_o                  : upstream must hold this cycle (slave drives)
//   occ_o                   : number of valid stages (slave drives)
//   stall_cnt_o             : saturating stall counter (slave, optional)
interface pipe_stage_chain_if #(
    parameter int CTRL_W = 2,
    parameter int DATA_W = 69,
    parameter int DEPTH  = 1
) ();
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic              valid_i;
    logic [CTRL_W-1:0] ctrl_i;
    logic [DATA_W-1:0] data_i;
    logic              stall_i;
    logic              flush_i;
    logic              valid_o;
    logic [CTRL_W-1:0] ctrl_o;
    logic [DATA_W-1:0] data_o;
    logic              busy_o;
    logic [OCC_W-1:0]  occ_o;
`ifdef PIPE_STALL_CNT_EN
    logic [15:0]       stall_cnt_o;
`endif

    modport slave (
        input  valid_i, ctrl_i, data_i,
        input  stall_i, flush_i,
        output valid_o, ctrl_o, data_o,
        output busy_o, occ_o
`ifdef PIPE_STALL_CNT_EN
        , output stall_cnt_o
`endif
    );

    modport master (
        output valid_i, ctrl_i, data_i,
        output stall_i, flush_i,
        input  valid_o, ctrl_o, data_o,
        input  busy_o, occ_o
`ifdef PIPE_STALL_CNT_EN
        , input stall_cnt_o
`endif
    );
endinterface

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: generic DEPTH-stage pipeline register with valid
// tracking, flush, bubble collapse under stall and upstream backpressure.
// Optional macro PIPE_STALL_CNT_EN adds a saturating stall-cycle counter.
//
// Ports:
//   clk_i : clock, rising edge
//   rst_i : synchronous active-low reset
//   bus   : pipe_stage_chain_if.slave (entry in/out, stall, flush,
//           busy, occupancy and optional stall count)
module pipe_stage_chain #(
    parameter int CTRL_W = 2,
    parameter int DATA_W = 69,
    parameter int DEPTH  = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    pipe_stage_chain_if.slave     bus
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]  vld_q, vld_d;
    logic [CTRL_W-1:0] ctrl_q [DEPTH];
    logic [CTRL_W-1:0] ctrl_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [DEPTH-1:0]  mv;
    logic [OCC_W-1:0]  occ_c;

    // A stage moves when downstream accepts or any stage from it
    // to the output is empty; that is what collapses bubbles.
    for (genvar i = 0; i < DEPTH; i++) begin : g_mv
        assign mv[i] = !bus.stall_i || !(&vld_q[DEPTH-1:i]);
    end

    always_comb begin
        vld_d  = vld_q;
        ctrl_d = ctrl_q;
        data_d = data_q;
        if (mv[0]) begin
            vld_d[0]  = bus.valid_i;
            ctrl_d[0] = bus.ctrl_i;
            data_d[0] = bus.data_i;
        end
        for (int i = 1; i < DEPTH; i++) begin
            if (mv[i]) begin
                vld_d[i]  = vld_q[i-1];
                ctrl_d[i] = ctrl_q[i-1];
                data_d[i] = data_q[i-1];
            end
        end
        // Flush drops valids only; data keeps loading as usual.
        if (bus.flush_i) begin
            vld_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ctrl_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            vld_q  <= vld_d;
            ctrl_q <= ctrl_d;
            data_q <= data_d;
        end
    end

    always_comb begin
        occ_c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_c = occ_c + OCC_W'(vld_q[i]);
        end
    end

    assign bus.valid_o = vld_q[DEPTH-1];
    assign bus.ctrl_o  = vld_q[DEPTH-1] ? ctrl_q[DEPTH-1]
                                        : '0;
    assign bus.data_o  = data_q[DEPTH-1];
    assign bus.busy_o  = (&vld_q) && bus.stall_i;
    assign bus.occ_o   = occ_c;

`ifdef PIPE_STALL_CNT_EN
    logic [15:0] scnt_q, scnt_d;

    always_comb begin
        scnt_d = scnt_q;
        if (bus.stall_i && vld_q[DEPTH-1] &&
            (scnt_q != 16'hFFFF)) begin
            scnt_d = scnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            scnt_q <= '0;
        end else begin
            scnt_q <= scnt_d;
        end
    end

    assign bus.stall_cnt_o = scnt_q;
`endif
endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb_pipe_stage_chain: drives DEPTH=3, 2 and 1 instances in lockstep and
// compares them against a position-based reference model.
module tb_pipe_stage_chain;
    logic        clk = 1'b0;
    logic        rs;
    logic        v;
    logic [1:0]  c;
    logic [68:0] d;
    logic        st;
    logic        fl;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    pipe_stage_chain_if #(.CTRL_W(2), .DATA_W(69), .DEPTH(3)) if3 ();
    pipe_stage_chain_if #(.CTRL_W(2), .DATA_W(69), .DEPTH(2)) if2 ();
    pipe_stage_chain_if #(.CTRL_W(2), .DATA_W(69), .DEPTH(1)) if1 ();

    assign if3.valid_i = v;
    assign if3.ctrl_i  = c;
    assign if3.data_i  = d;
    assign if3.stall_i = st;
    assign if3.flush_i = fl;
    assign if2.valid_i = v;
    assign if2.ctrl_i  = c;
    assign if2.data_i  = d;
    assign if2.stall_i = st;
    assign if2.flush_i = fl;
    assign if1.valid_i = v;
    assign if1.ctrl_i  = c;
    assign if1.data_i  = d;
    assign if1.stall_i = st;
    assign if1.flush_i = fl;

    pipe_stage_chain #(.CTRL_W(2), .DATA_W(69), .DEPTH(3)) u3 (
        .clk_i(clk), .rst_i(rs), .bus(if3));
    pipe_stage_chain #(.CTRL_W(2), .DATA_W(69), .DEPTH(2)) u2 (
        .clk_i(clk), .rst_i(rs), .bus(if2));
    pipe_stage_chain #(.CTRL_W(2), .DATA_W(69), .DEPTH(1)) u1 (
        .clk_i(clk), .rst_i(rs), .bus(if1));

    // Reference model: each pipeline is an ordered list of entries
    // (oldest first) tagged with the stage index they occupy.
    int          dep  [3] = '{3, 2, 1};
    int          mpos [3][3];
    logic [1:0]  mctl [3][3];
    logic [68:0] mdat [3][3];
    int          mn   [3];
    int unsigned mcnt [3];

    task automatic chk(input string tag, input logic [68:0] obs,
                       input logic [68:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic chk_m(input int m, input logic vo,
                         input logic [1:0] co, input logic [68:0] dd,
                         input int occ, input logic bz);
        logic ev;
        string p;
        p = $sformatf("D%0d", dep[m]);
        ev = (mn[m] > 0) && (mpos[m][0] == dep[m] - 1);
        chk({p, ".valid_o"}, 69'(vo), 69'(ev));
        chk({p, ".ctrl_o"}, 69'(co), ev ? 69'(mctl[m][0]) : 69'd0);
        if (ev) chk({p, ".data_o"}, dd, mdat[m][0]);
        chk({p, ".occ_o"}, 69'(occ), 69'(mn[m]));
        chk({p, ".busy_o"}, 69'(bz), 69'((mn[m] == dep[m]) && st));
    endtask

    task automatic model_step();
        int dd, k2, bound, np;
        logic vo;
        for (int m = 0; m < 3; m++) begin
            dd = dep[m];
            if (!rs) begin
                mn[m] = 0;
                mcnt[m] = 0;
            end else begin
                vo = (mn[m] > 0) && (mpos[m][0] == dd - 1);
                if (st && vo && mcnt[m] < 65535) mcnt[m]++;
                if (fl) begin
                    mn[m] = 0;
                end else begin
                    // An entry advances one stage unless the entry
                    // ahead of it stays put directly in front.
                    k2 = 0;
                    bound = st ? dd : dd + 1;
                    for (int k = 0; k < mn[m]; k++) begin
                        np = mpos[m][k] + 1;
                        if (np > bound - 1) np = bound - 1;
                        if (np < dd) begin
                            mpos[m][k2] = np;
                            mctl[m][k2] = mctl[m][k];
                            mdat[m][k2] = mdat[m][k];
                            bound = np;
                            k2++;
                        end
                    end
                    if (v && bound > 0) begin
                        mpos[m][k2] = 0;
                        mctl[m][k2] = c;
                        mdat[m][k2] = d;
                        k2++;
                    end
                    mn[m] = k2;
                end
            end
        end
    endtask

    task automatic step(input logic iv, input logic [1:0] ic,
                        input logic [68:0] id, input logic ist,
                        input logic ifl, input logic irs);
        v = iv; c = ic; d = id; st = ist; fl = ifl; rs = irs;
        #1;
        chk_m(0, if3.valid_o, if3.ctrl_o, if3.data_o,
              int'(if3.occ_o), if3.busy_o);
        chk_m(1, if2.valid_o, if2.ctrl_o, if2.data_o,
              int'(if2.occ_o), if2.busy_o);
        chk_m(2, if1.valid_o, if1.ctrl_o, if1.data_o,
              int'(if1.occ_o), if1.busy_o);
`ifdef PIPE_STALL_CNT_EN
        chk("D3.stall_cnt_o", 69'(if3.stall_cnt_o), 69'(mcnt[0]));
        chk("D2.stall_cnt_o", 69'(if2.stall_cnt_o), 69'(mcnt[1]));
        chk("D1.stall_cnt_o", 69'(if1.stall_cnt_o), 69'(mcnt[2]));
`endif
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [68:0] rd;
        v = 0; c = 0; d = 0; st = 0; fl = 0; rs = 0;
        for (int m = 0; m < 3; m++) begin
            mn[m] = 0;
            mcnt[m] = 0;
        end
        @(posedge clk);
        #1;

        // Reset with an entry presented
        step(1, 2'b11, 69'h1, 0, 0, 0);
        step(1, 2'b11, 69'h1, 0, 0, 0);
        chk("rst.D3.data_o", if3.data_o, 69'h0);
        chk("rst.D2.data_o", if2.data_o, 69'h0);
        chk("rst.D1.data_o", if1.data_o, 69'h0);

        // Latency / throughput
        step(1, 2'b11, 69'd1, 0, 0, 1);
        step(1, 2'b11, 69'd2, 0, 0, 1);
        step(1, 2'b11, 69'd3, 0, 0, 1);
        chk("lat.D3.data_o", if3.data_o, 69'd1);
        chk("lat.D3.ctrl_o", 69'(if3.ctrl_o), 69'd3);
        step(1, 2'b11, 69'd4, 0, 0, 1);
        step(0, 2'b00, 69'd0, 0, 0, 1);
        step(0, 2'b00, 69'd0, 0, 0, 1);
        step(0, 2'b00, 69'd0, 0, 0, 1);

        // Bubble collapse: A, idle, B, stall, C, D blocked, release
        step(1, 2'b01, 69'hA, 0, 0, 1);
        step(0, 2'b00, 69'h0, 0, 0, 1);
        step(1, 2'b10, 69'hB, 0, 0, 1);
        step(0, 2'b00, 69'h0, 1, 0, 1);
        step(0, 2'b00, 69'h0, 1, 0, 1);
        chk("coll.D3.occ_o", 69'(if3.occ_o), 69'd2);
        step(1, 2'b11, 69'hC, 1, 0, 1);
        chk("coll.D3.occ_full", 69'(if3.occ_o), 69'd3);
        step(1, 2'b01, 69'hD, 1, 0, 1);
        step(1, 2'b01, 69'hD, 1, 0, 1);
        step(1, 2'b01, 69'hD, 0, 0, 1);
        step(0, 2'b00, 69'h0, 0, 0, 1);
        step(0, 2'b00, 69'h0, 0, 0, 1);
        step(0, 2'b00, 69'h0, 0, 0, 1);
        step(0, 2'b00, 69'h0, 0, 0, 1);

        // Flush while full and stalled, with a new entry E
        step(1, 2'b11, 69'h11, 1, 0, 1);
        step(1, 2'b11, 69'h12, 1, 0, 1);
        step(1, 2'b11, 69'h13, 1, 0, 1);
        step(1, 2'b11, 69'hE, 1, 1, 1);
        chk("flush.D2.occ_o", 69'(if2.occ_o), 69'd0);
        step(0, 2'b00, 69'h0, 0, 0, 1);
        step(0, 2'b00, 69'h0, 0, 0, 1);
        step(0, 2'b00, 69'h0, 0, 0, 1);

        // Stall counter: 5 stalled cycles with an output entry
        step(1, 2'b01, 69'h5, 0, 0, 0);
        step(1, 2'b01, 69'h5, 0, 0, 1);
        step(0, 2'b00, 69'h0, 0, 0, 1);
        step(0, 2'b00, 69'h0, 0, 0, 1);
        step(0, 2'b00, 69'h0, 1, 0, 1);
        step(0, 2'b00, 69'h0, 1, 0, 1);
        step(0, 2'b00, 69'h0, 1, 0, 1);
        step(0, 2'b00, 69'h0, 1, 0, 1);
        step(0, 2'b00, 69'h0, 1, 1, 1);
        step(0, 2'b00, 69'h0, 1, 0, 1);
        step(0, 2'b00, 69'h0, 1, 0, 1);
        step(0, 2'b00, 69'h0, 1, 0, 1);
        step(0, 2'b00, 69'h0, 0, 1, 1);
`ifdef PIPE_STALL_CNT_EN
        chk("scnt.D3", 69'(if3.stall_cnt_o), 69'd5);
`endif

        // Randomised traffic
        for (int t = 0; t < 600; t++) begin
            rd = {5'($urandom), $urandom, $urandom};
            step($urandom_range(0, 9) < 7,
                 2'($urandom),
                 rd,
                 $urandom_range(0, 9) < 4,
                 $urandom_range(0, 99) < 4,
                 $urandom_range(0, 99) >= 2);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
